// File: rtl/qtree_stream_loader.sv
// AXI-stream front end that loads postfix-encoded QTree batches into a DUT heap and launches the DUT.
// Optional status counters are enabled by defining QTREE_LOADER_STATUS_EN.
module qtree_stream_loader #(
   parameter int NODE_W      = 67,
   parameter int PTR_W       = 16,
   parameter int N_INPUTS    = 2,
   parameter int STACK_DEPTH = 256,
   parameter int RESULT_W    = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NODE_W-1:0]           s_tdata,
   input  logic                        s_tlast,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   output logic [NODE_W-1:0]           wr_d,
   input  logic                        wr_r,
   input  logic [PTR_W:0]              ptr_d,
   output logic                        ptr_r,
   output logic                        go_d,
   input  logic                        go_r,
   output logic [N_INPUTS*(PTR_W+1)-1:0] root_d,
   input  logic [N_INPUTS-1:0]         root_r,
   input  logic [RESULT_W:0]           res_d,
   output logic                        res_r,
   output logic [RESULT_W-1:0]         result_data,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic                        busy,
   output logic                        err
`ifdef QTREE_LOADER_STATUS_EN
   ,
   output logic [31:0]                 node_count,
   output logic [$clog2(STACK_DEPTH):0] max_sp
`endif
);

   localparam int SPW = $clog2(STACK_DEPTH) + 1;
   localparam int IW  = $clog2(STACK_DEPTH);
   localparam int KW  = $clog2(N_INPUTS + 1);

   typedef enum logic [2:0] {LOAD, WRITE, WAIT_PTR, LAUNCH, RUN, OUT} state_t;

   state_t                    state_r, state_n;
   logic [SPW-1:0]            sp_r, sp_n, sp_push_s;
   logic [KW-1:0]             k_r, k_n;
   logic                      last_r, last_n;
   logic [NODE_W-1:0]         wr_d_r, wr_d_n;
   logic [N_INPUTS*PTR_W-1:0] root_pl_r, root_pl_n;
   logic [N_INPUTS-1:0]       root_v_r, root_v_n;
   logic                      go_v_r, go_v_n;
   logic                      err_r, err_n;
   logic [RESULT_W-1:0]       res_data_r, res_data_n;
   logic                      res_valid_r, res_valid_n;
   logic                      ld_rdy_r, ptr_rdy_r, res_rdy_r, busy_r;
   logic                      push_s;
   logic [N_INPUTS:0]         pend_s;
   logic [PTR_W-1:0]          stack_r [STACK_DEPTH];

   // Next-state and datapath decode for the load/launch/result sequence
   always_comb begin
      state_n     = state_r;
      sp_n        = sp_r;
      k_n         = k_r;
      last_n      = last_r;
      wr_d_n      = wr_d_r;
      root_pl_n   = root_pl_r;
      root_v_n    = root_v_r;
      go_v_n      = go_v_r;
      err_n       = err_r;
      res_data_n  = res_data_r;
      res_valid_n = res_valid_r;
      push_s      = 1'b0;
      sp_push_s   = sp_r;
      pend_s      = {root_v_r, go_v_r} & ~{root_r, go_r};
      case (state_r)
         LOAD: begin
            if (s_tvalid && ld_rdy_r) begin
               if (s_tdata[2:1] == 2'd2) begin
                  if (sp_r < SPW'(4)) begin
                     err_n = 1'b1;
                  end else begin
                     // child j is the j-th most recent pointer on the stack
                     wr_d_n    = s_tdata;
                     wr_d_n[0] = 1'b1;
                     for (int j = 0; j < 4; j++) begin
                        wr_d_n[3+j*PTR_W +: PTR_W] = stack_r[IW'(sp_r - SPW'(j + 1))];
                     end
                     sp_n    = sp_r - SPW'(4);
                     last_n  = s_tlast;
                     state_n = WRITE;
                  end
               end else begin
                  wr_d_n    = s_tdata;
                  wr_d_n[0] = 1'b1;
                  last_n    = s_tlast;
                  state_n   = WRITE;
               end
            end else begin
               state_n = LOAD;
            end
         end
         WRITE: begin
            if (wr_r) begin
               wr_d_n[0] = 1'b0;
               state_n   = WAIT_PTR;
            end else begin
               state_n = WRITE;
            end
         end
         WAIT_PTR: begin
            if (ptr_d[0] && ptr_rdy_r) begin
               if (sp_r == SPW'(STACK_DEPTH)) begin
                  err_n = 1'b1;
               end else begin
                  push_s    = 1'b1;
                  sp_push_s = sp_r + SPW'(1);
               end
               sp_n = sp_push_s;
               if (last_r) begin
                  // a complete tree must reduce to exactly its root pointer
                  root_pl_n[int'(k_r)*PTR_W +: PTR_W] = ptr_d[PTR_W:1];
                  if (sp_push_s != SPW'(1)) begin
                     err_n = 1'b1;
                  end else begin
                     err_n = err_r;
                  end
                  sp_n = {SPW{1'b0}};
                  k_n  = k_r + KW'(1);
                  if (k_n == KW'(N_INPUTS)) begin
                     go_v_n   = 1'b1;
                     root_v_n = {N_INPUTS{1'b1}};
                     state_n  = LAUNCH;
                  end else begin
                     state_n = LOAD;
                  end
               end else begin
                  state_n = LOAD;
               end
            end else begin
               state_n = WAIT_PTR;
            end
         end
         LAUNCH: begin
            go_v_n   = pend_s[0];
            root_v_n = pend_s[N_INPUTS:1];
            if (pend_s == {(N_INPUTS+1){1'b0}}) begin
               state_n = RUN;
            end else begin
               state_n = LAUNCH;
            end
         end
         RUN: begin
            if (res_d[0] && res_rdy_r) begin
               res_data_n  = res_d[RESULT_W:1];
               res_valid_n = 1'b1;
               state_n     = OUT;
            end else begin
               state_n = RUN;
            end
         end
         OUT: begin
            if (result_ready) begin
               res_valid_n = 1'b0;
               k_n         = {KW{1'b0}};
               state_n     = LOAD;
            end else begin
               state_n = OUT;
            end
         end
         default: begin
            state_n = LOAD;
         end
      endcase
   end

   // State and output registers; handshake readies follow the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= LOAD;
         sp_r        <= {SPW{1'b0}};
         k_r         <= {KW{1'b0}};
         last_r      <= 1'b0;
         wr_d_r      <= {NODE_W{1'b0}};
         root_pl_r   <= {(N_INPUTS*PTR_W){1'b0}};
         root_v_r    <= {N_INPUTS{1'b0}};
         go_v_r      <= 1'b0;
         err_r       <= 1'b0;
         res_data_r  <= {RESULT_W{1'b0}};
         res_valid_r <= 1'b0;
         ld_rdy_r    <= 1'b0;
         ptr_rdy_r   <= 1'b0;
         res_rdy_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         sp_r        <= sp_n;
         k_r         <= k_n;
         last_r      <= last_n;
         wr_d_r      <= wr_d_n;
         root_pl_r   <= root_pl_n;
         root_v_r    <= root_v_n;
         go_v_r      <= go_v_n;
         err_r       <= err_n;
         res_data_r  <= res_data_n;
         res_valid_r <= res_valid_n;
         ld_rdy_r    <= (state_n == LOAD);
         ptr_rdy_r   <= (state_n == WAIT_PTR);
         res_rdy_r   <= (state_n == RUN);
         busy_r      <= !((state_n == LOAD) && (k_n == {KW{1'b0}}) && (sp_n == {SPW{1'b0}}));
      end
   end

   // Pointer stack storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_r[sp_r[IW-1:0]] <= ptr_d[PTR_W:1];
      end
   end

`ifdef QTREE_LOADER_STATUS_EN
   logic [31:0]    node_count_r;
   logic [SPW-1:0] max_sp_r;

   // Saturating heap-write counter and stack high-water mark
   always_ff @(posedge clk) begin
      if (reset) begin
         node_count_r <= 32'd0;
         max_sp_r     <= {SPW{1'b0}};
      end else begin
         if ((state_r == WRITE) && wr_r && (node_count_r != 32'hFFFF_FFFF)) begin
            node_count_r <= node_count_r + 32'd1;
         end
         if (sp_n > max_sp_r) begin
            max_sp_r <= sp_n;
         end
      end
   end

   assign node_count = node_count_r;
   assign max_sp     = max_sp_r;
`endif

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_root
      assign root_d[g*(PTR_W+1) +: PTR_W+1] = {root_pl_r[g*PTR_W +: PTR_W], root_v_r[g]};
   end

   assign s_tready     = ld_rdy_r;
   assign wr_d         = wr_d_r;
   assign ptr_r        = ptr_rdy_r;
   assign go_d         = go_v_r;
   assign res_r        = res_rdy_r;
   assign result_data  = res_data_r;
   assign result_valid = res_valid_r;
   assign busy         = busy_r;
   assign err          = err_r;

endmodule

// File: tb/tb_qtree_stream_loader.sv
// Directed bench for qtree_stream_loader (default parameters, N_INPUTS=2, STACK_DEPTH=256).
module tb_qtree_stream_loader;

   localparam int NODE_W = 67;
   localparam int PTR_W  = 16;
   localparam int NI     = 2;
   localparam int RW     = 32;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NODE_W-1:0]       s_tdata = '0;
   logic                    s_tlast = 1'b0;
   logic                    s_tvalid = 1'b0;
   logic                    s_tready;
   logic [NODE_W-1:0]       wr_d;
   logic                    wr_r = 1'b0;
   logic [PTR_W:0]          ptr_d = '0;
   logic                    ptr_r;
   logic                    go_d;
   logic                    go_r = 1'b0;
   logic [NI*(PTR_W+1)-1:0] root_d;
   logic [NI-1:0]           root_r = '0;
   logic [RW:0]             res_d = '0;
   logic                    res_r;
   logic [RW-1:0]           result_data;
   logic                    result_valid;
   logic                    result_ready = 1'b0;
   logic                    busy;
   logic                    err;
`ifdef QTREE_LOADER_STATUS_EN
   logic [31:0]             node_count;
   logic [8:0]              max_sp;
`endif

   int checks = 0;
   int errors = 0;

   qtree_stream_loader dut (
      .clk(clk), .reset(reset),
      .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .wr_d(wr_d), .wr_r(wr_r), .ptr_d(ptr_d), .ptr_r(ptr_r),
      .go_d(go_d), .go_r(go_r), .root_d(root_d), .root_r(root_r),
      .res_d(res_d), .res_r(res_r),
      .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy), .err(err)
`ifdef QTREE_LOADER_STATUS_EN
      , .node_count(node_count), .max_sp(max_sp)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: timeout waiting for handshake", tag);
   endtask

   task automatic send_beat(input logic [NODE_W-1:0] d, input logic last);
      int n = 0;
      s_tdata  = d;
      s_tlast  = last;
      s_tvalid = 1'b1;
      while (!s_tready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeout("s_tready");
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic write_ack();
      wr_r = 1'b1;
      tick();
      wr_r = 1'b0;
   endtask

   task automatic give_ptr(input logic [PTR_W-1:0] p);
      int n = 0;
      while (!ptr_r && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeout("ptr_r");
      ptr_d = {p, 1'b1};
      tick();
      ptr_d = '0;
   endtask

   task automatic leaf(input logic [63:0] pay, input logic [PTR_W-1:0] p, input logic last);
      logic [NODE_W-1:0] d;
      d = {pay, 2'b00, 1'b1};
      send_beat(d, last);
      chk("leaf_wr_d", wr_d, d);
      write_ack();
      give_ptr(p);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_s_tready"}, s_tready, 1'b0);
      chk({tag, "_wr_d"}, wr_d, '0);
      chk({tag, "_ptr_r"}, ptr_r, 1'b0);
      chk({tag, "_go_d"}, go_d, 1'b0);
      chk({tag, "_root_d"}, root_d, '0);
      chk({tag, "_res_r"}, res_r, 1'b0);
      chk({tag, "_result"}, {result_valid, result_data}, '0);
      chk({tag, "_busy_err"}, {busy, err}, 2'b00);
   endtask

   initial begin
      logic [NODE_W-1:0] d;

      // reset state
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      chk("rel_s_tready", s_tready, 1'b1);
      chk("rel_busy", busy, 1'b0);

      // batch A: two single-leaf trees, wr_r held low 5 cycles
      d = {64'hDEAD_BEEF_0000_1234, 2'b00, 1'b1};
      send_beat(d, 1'b1);
      chk("a0_wr_d", wr_d, d);
      chk("a0_busy", busy, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("a0_wr_hold", wr_d, d);
      end
      write_ack();
      chk("a0_wr_drop", wr_d[0], 1'b0);
      chk("a0_ptr_r", ptr_r, 1'b1);
      give_ptr(16'h0005);
      chk("a0_err", err, 1'b0);
      chk("a0_busy_k1", busy, 1'b1);
      chk("a0_go_idle", go_d, 1'b0);
      res_d = 33'h1FF;
      tick();
      chk("stray_res", {result_valid, res_r}, 2'b00);
      res_d = '0;
      leaf(64'h0, 16'h0007, 1'b1);
      chk("a_go", go_d, 1'b1);
      chk("a_roots", root_d, {17'h0000F, 17'h0000B});
      go_r   = 1'b1;
      root_r = 2'b01;
      tick();
      go_r   = 1'b0;
      root_r = 2'b00;
      chk("a_go_drop", go_d, 1'b0);
      chk("a_root0_drop", root_d, {17'h0000F, 17'h0000A});
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("a_root1_hold", root_d, {17'h0000F, 17'h0000A});
         chk("a_no_run", res_r, 1'b0);
      end
      root_r = 2'b10;
      tick();
      root_r = 2'b00;
      chk("a_roots_done", root_d, {17'h0000E, 17'h0000A});
      chk("a_run", res_r, 1'b1);
      res_d = {32'h0000_0015, 1'b1};
      tick();
      chk("a_res", {result_valid, result_data}, {1'b1, 32'h0000_0015});
      chk("a_res_r_off", res_r, 1'b0);
      res_d = {32'h0000_1234, 1'b1};
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("a_res_hold", {result_valid, result_data}, {1'b1, 32'h0000_0015});
      end
      res_d = '0;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("a_res_done", {result_valid, result_data}, {1'b0, 32'h0000_0015});
      chk("a_idle", {busy, s_tready}, 2'b01);

      // batch B: four leaves then a node, second batch with k restarted
      for (int i = 1; i <= 4; i++) begin
         leaf(64'h0, 16'(i), 1'b0);
      end
      send_beat({64'hAAAA_BBBB_CCCC_DDDD, 2'b10, 1'b0}, 1'b1);
      chk("b_node_wr", wr_d, {16'd1, 16'd2, 16'd3, 16'd4, 2'b10, 1'b1});
      write_ack();
      give_ptr(16'h0009);
      chk("b_err", err, 1'b0);
      chk("b_no_launch", go_d, 1'b0);
      leaf(64'h5, 16'h1234, 1'b1);
      chk("b_roots", root_d, {17'h02469, 17'h00013});
      chk("b_go", go_d, 1'b1);
      go_r   = 1'b1;
      root_r = 2'b11;
      tick();
      go_r   = 1'b0;
      root_r = 2'b00;
      chk("b_run", {go_d, res_r}, 2'b01);
      res_d = {32'hCAFE_F00D, 1'b1};
      tick();
      res_d = '0;
      chk("b_res", {result_valid, result_data}, {1'b1, 32'hCAFE_F00D});
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("b_res_done", result_valid, 1'b0);

      // underflow: node with sp=2
      leaf(64'h0, 16'h0011, 1'b0);
      leaf(64'h0, 16'h0012, 1'b0);
      send_beat({64'h0, 2'b10, 1'b1}, 1'b0);
      chk("uf_err", err, 1'b1);
      chk("uf_no_wr", wr_d[0], 1'b0);
      chk("uf_tready", s_tready, 1'b1);

      // reset while waiting for a pointer
      send_beat({64'h77, 2'b00, 1'b1}, 1'b0);
      write_ack();
      chk("rs_ptr_r", ptr_r, 1'b1);
      reset = 1'b1;
      tick();
      check_all_zero("rs");
      reset = 1'b0;
      tick();
      chk("rs_tready", s_tready, 1'b1);
      chk("rs_busy_err", {busy, err}, 2'b00);
`ifdef QTREE_LOADER_STATUS_EN
      chk("rs_node_count", node_count, 32'd0);
`endif

      // overflow: 257 pushes into a 256-entry stack
      for (int i = 0; i < 257; i++) begin
         leaf(64'(i), 16'(i), 1'b0);
         if (i == 255) chk("of_full_ok", err, 1'b0);
      end
      chk("of_err", err, 1'b1);
      chk("of_busy", busy, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
